// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single data-cache port between refill, store-drain and load
// requesters, and tracks accepted accesses through the 2-cycle cache pipeline.
module dcache_port_arbiter #(
    parameter int TAG_W      = 7,
    parameter int STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             rf_req,
    input  logic [31:0]      rf_addr,
    output logic             rf_gnt,
    input  logic             wr_req,
    input  logic [31:0]      wr_addr,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_strb,
    input  logic             wr_urgent,
    output logic             wr_gnt,
    input  logic             rd_req,
    input  logic [31:0]      rd_addr,
    input  logic [1:0]       rd_size,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_gnt,
    output logic             dc_valid,
    output logic [1:0]       dc_op,
    output logic [31:0]      dc_addr,
    output logic [31:0]      dc_wdata,
    output logic [3:0]       dc_strb,
    output logic [1:0]       dc_size,
    input  logic             dc_ready,
    input  logic             dc_hit,
    input  logic [31:0]      dc_rdata,
    output logic             rsp_valid,
    output logic [1:0]       rsp_op,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_addr,
    output logic             rsp_hit,
    output logic [31:0]      rsp_data
);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b10;
    localparam logic [1:0] OP_RF   = 2'b11;
    localparam int         CW      = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic             valid;
        logic [1:0]       op;
        logic [31:0]      addr;
        logic [TAG_W-1:0] tag;
    } stage_t;

    stage_t           s1;
    stage_t           s2;
    logic             s2_kill;
    logic             flush_d;
    logic [CW-1:0]    starve;
    logic             line_busy;
    logic             rd_elig;
    logic             wr_force;
    logic             sel_rf;
    logic             sel_wr;
    logic             sel_rd;
    logic             accept;
    logic [TAG_W-1:0] dc_tag;
    logic             unused_rf_offset;

    assign unused_rf_offset = ^rf_addr[3:0];

    // A load may not hit a line whose refill is still in the cache pipeline.
    assign line_busy =
        (s1.valid & (s1.op == OP_RF) & (s1.addr[31:4] == rd_addr[31:4])) |
        (s2.valid & (s2.op == OP_RF) & (s2.addr[31:4] == rd_addr[31:4]));

    assign rd_elig  = rd_req & ~flush & ~flush_d & ~line_busy;
    assign wr_force = wr_req & (wr_urgent | (starve == CW'(STARVE_MAX)));

    assign sel_rf = ~rst & rf_req;
    assign sel_wr = ~rst & ~rf_req & (wr_force | (wr_req & ~rd_elig));
    assign sel_rd = ~rst & ~rf_req & ~wr_force & rd_elig;

    always_comb begin
        dc_valid = 1'b0;
        dc_op    = OP_NONE;
        dc_addr  = '0;
        dc_wdata = '0;
        dc_strb  = '0;
        dc_size  = '0;
        dc_tag   = '0;
        unique case (1'b1)
            sel_rf: begin
                dc_valid = 1'b1;
                dc_op    = OP_RF;
                dc_addr  = {rf_addr[31:4], 4'h0};
            end
            sel_wr: begin
                dc_valid = 1'b1;
                dc_op    = OP_WR;
                dc_addr  = wr_addr;
                dc_wdata = wr_data;
                dc_strb  = wr_strb;
            end
            sel_rd: begin
                dc_valid = 1'b1;
                dc_op    = OP_RD;
                dc_addr  = rd_addr;
                dc_size  = rd_size;
                dc_tag   = rd_tag;
            end
            default: ;
        endcase
    end

    assign accept = dc_valid & dc_ready;
    assign rf_gnt = sel_rf & accept;
    assign wr_gnt = sel_wr & accept;
    assign rd_gnt = sel_rd & accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            s2_kill <= 1'b0;
            flush_d <= 1'b0;
            starve  <= '0;
        end else begin
            s1      <= '{valid: accept, op: dc_op, addr: dc_addr, tag: dc_tag};
            s2      <= s1;
            s2_kill <= flush & (s1.op == OP_RD);
            flush_d <= flush;
            if (wr_gnt) begin
                starve <= '0;
            end else if (wr_req && (starve != CW'(STARVE_MAX))) begin
                starve <= starve + CW'(1);
            end
        end
    end

    // A flush coinciding with the response cycle also suppresses a load.
    assign rsp_valid = ~rst & s2.valid & ~s2_kill &
                       ~(flush & (s2.op == OP_RD));
    assign rsp_op    = s2.op;
    assign rsp_tag   = s2.tag;
    assign rsp_addr  = s2.addr;
    assign rsp_hit   = dc_hit;
    assign rsp_data  = dc_rdata;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Randomized and directed bench for dcache_port_arbiter with a
// cycle-history reference model and a response scoreboard.
module tb_dcache_port_arbiter;

    localparam int TAG_W = 7;
    localparam int SMAX  = 8;

    logic             clk = 1'b0;
    logic             rst, flush;
    logic             rf_req, wr_req, wr_urgent, rd_req;
    logic [31:0]      rf_addr, wr_addr, wr_data, rd_addr, dc_rdata;
    logic [3:0]       wr_strb;
    logic [1:0]       rd_size;
    logic [TAG_W-1:0] rd_tag;
    logic             dc_ready, dc_hit;
    logic             rf_gnt, wr_gnt, rd_gnt, dc_valid;
    logic [1:0]       dc_op, dc_size, rsp_op;
    logic [31:0]      dc_addr, dc_wdata, rsp_addr, rsp_data;
    logic [3:0]       dc_strb;
    logic             rsp_valid, rsp_hit;
    logic [TAG_W-1:0] rsp_tag;

    dcache_port_arbiter #(.TAG_W(TAG_W), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .rf_req(rf_req), .rf_addr(rf_addr), .rf_gnt(rf_gnt),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .wr_urgent(wr_urgent), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size),
        .rd_tag(rd_tag), .rd_gnt(rd_gnt),
        .dc_valid(dc_valid), .dc_op(dc_op), .dc_addr(dc_addr),
        .dc_wdata(dc_wdata), .dc_strb(dc_strb), .dc_size(dc_size),
        .dc_ready(dc_ready), .dc_hit(dc_hit), .dc_rdata(dc_rdata),
        .rsp_valid(rsp_valid), .rsp_op(rsp_op), .rsp_tag(rsp_tag),
        .rsp_addr(rsp_addr), .rsp_hit(rsp_hit), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               due;
        logic [1:0]       op;
        logic [31:0]      addr;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t        sbq[$];
    bit          flush_at[int];
    logic [27:0] rf_line[int];
    int          cyc      = 0;
    int          checks   = 0;
    int          failures = 0;
    int          starve   = 0;
    bit          mon_on   = 0;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    task automatic idle();
        rst = 0; flush = 0; rf_req = 0; wr_req = 0; rd_req = 0;
        wr_urgent = 0; dc_ready = 1; dc_hit = 0; dc_rdata = 0;
        rf_addr = 0; wr_addr = 0; wr_data = 0; wr_strb = 0;
        rd_addr = 0; rd_size = 0; rd_tag = 0;
    endtask

    // Model: the winner follows the priority rules from the current
    // requests plus the recorded flush/refill history of earlier cycles.
    task automatic tick();
        logic [1:0]  w;
        logic [31:0] a;
        bit          fd, blk, elig, acc;
        #1;
        fd  = flush_at.exists(cyc - 1) && flush_at[cyc - 1];
        blk = 0;
        for (int k = 1; k <= 2; k++)
            if (rf_line.exists(cyc - k) && rf_line[cyc - k] == rd_addr[31:4])
                blk = 1;
        elig = rd_req && !flush && !fd && !blk;
        if (rst) w = 2'd0;
        else if (rf_req) w = 2'd3;
        else if (wr_req && (wr_urgent || starve == SMAX)) w = 2'd2;
        else if (elig) w = 2'd1;
        else if (wr_req) w = 2'd2;
        else w = 2'd0;
        a = (w == 3) ? {rf_addr[31:4], 4'h0} :
            (w == 2) ? wr_addr : (w == 1) ? rd_addr : 32'h0;
        acc = (w != 0) && dc_ready;
        chk("dc_valid", 32'(dc_valid), 32'(w != 0));
        chk("dc_op", 32'(dc_op), 32'(w));
        chk("dc_addr", dc_addr, a);
        chk("dc_wdata", dc_wdata, (w == 2) ? wr_data : 32'h0);
        chk("dc_strb", 32'(dc_strb), (w == 2) ? 32'(wr_strb) : 32'h0);
        chk("dc_size", 32'(dc_size), (w == 1) ? 32'(rd_size) : 32'h0);
        chk("grants", 32'({rf_gnt, wr_gnt, rd_gnt}),
            32'({acc && w == 3, acc && w == 2, acc && w == 1}));
        if (rst) begin
            sbq.delete();
            rf_line.delete();
            starve = 0;
        end else begin
            if (acc)
                sbq.push_back('{cyc + 2, w, a,
                                (w == 1) ? rd_tag : TAG_W'(0)});
            if (acc && w == 3) rf_line[cyc] = a[31:4];
            if (acc && w == 2) starve = 0;
            else if (wr_req && starve < SMAX) starve++;
        end
        flush_at[cyc] = flush && !rst;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   have, kill;
        if (mon_on) begin
            have = 0;
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                e = sbq.pop_front();
                chk("rsp_missed", 32'(cyc), 32'(e.due));
            end
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e    = sbq.pop_front();
                have = 1;
            end
            kill = have && e.op == 2'd1 &&
                   ((flush_at.exists(cyc - 1) && flush_at[cyc - 1]) || flush);
            chk("rsp_valid", 32'(rsp_valid), 32'(have && !kill));
            if (have && !kill && rsp_valid) begin
                chk("rsp_op", 32'(rsp_op), 32'(e.op));
                chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
                chk("rsp_addr", rsp_addr, e.addr);
                chk("rsp_hit", 32'(rsp_hit), 32'(dc_hit));
                chk("rsp_data", rsp_data, dc_rdata);
            end
        end
    end

    initial begin
        idle();
        rst = 1;
        tick();
        tick();
        rst    = 0;
        mon_on = 1;

        // Single load, hit returned two cycles later.
        rd_req = 1; rd_addr = 32'h1000_0040; rd_size = 2; rd_tag = 5;
        #1;
        chk("t1_rd_gnt", 32'(rd_gnt), 32'd1);
        chk("t1_dc_op", 32'(dc_op), 32'd1);
        tick();
        rd_req = 0;
        tick();
        dc_hit = 1; dc_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_op", 32'(rsp_op), 32'd1);
        chk("t1_rsp_tag", 32'(rsp_tag), 32'd5);
        chk("t1_rsp_data", rsp_data, 32'hDEAD_BEEF);
        tick();
        idle();

        // All three requesting: refill first, then read or urgent write.
        rf_req = 1; rf_addr = 32'h4000_0000;
        wr_req = 1; wr_addr = 32'h5000_0004; wr_data = 32'h1234_5678;
        wr_strb = 4'hF;
        rd_req = 1; rd_addr = 32'h1000_0040; rd_tag = 6;
        #1;
        chk("t2_rf_only", 32'({rf_gnt, wr_gnt, rd_gnt}), 32'b100);
        tick();
        rf_req = 0;
        #1;
        chk("t2_rd_gnt", 32'({wr_gnt, rd_gnt}), 32'b01);
        tick();
        wr_urgent = 1;
        #1;
        chk("t2_wr_urgent", 32'({wr_gnt, rd_gnt}), 32'b10);
        tick();
        wr_urgent = 0;

        // Starvation: reads win 8 times, then the write, then reads again.
        for (int i = 0; i < SMAX; i++) begin
            #1;
            chk("t3_rd_wins", 32'(rd_gnt), 32'd1);
            tick();
        end
        #1;
        chk("t3_wr_starved", 32'(wr_gnt), 32'd1);
        tick();
        #1;
        chk("t3_counter_cleared", 32'(rd_gnt), 32'd1);
        tick();
        idle();

        // Flush kills the in-flight load and blocks loads for two cycles.
        rd_req = 1; rd_addr = 32'h1000_0100; rd_tag = 9;
        #1;
        chk("t4_rd_gnt_t", 32'(rd_gnt), 32'd1);
        tick();
        flush = 1;
        #1;
        chk("t4_rd_blk_t1", 32'(rd_gnt), 32'd0);
        tick();
        flush = 0;
        #1;
        chk("t4_rd_blk_t2", 32'(rd_gnt), 32'd0);
        chk("t4_no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        #1;
        chk("t4_rd_gnt_t3", 32'(rd_gnt), 32'd1);
        tick();
        idle();
        wr_req = 1; wr_addr = 32'h5000_0000; wr_strb = 4'h3;
        tick();
        wr_req = 0; flush = 1;
        tick();
        flush = 0;
        #1;
        chk("t4_wr_survives", 32'({rsp_valid, rsp_op}), 32'b110);
        tick();

        // Read blocked behind an in-flight refill of the same line.
        idle();
        rf_req = 1; rf_addr = 32'h2000_0010;
        #1;
        chk("t5_rf_gnt", 32'(rf_gnt), 32'd1);
        tick();
        rf_req = 0;
        rd_req = 1; rd_addr = 32'h2000_0018; rd_tag = 3;
        wr_req = 1; wr_addr = 32'h3000_0000; wr_strb = 4'hF;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t5_blocked", 32'({wr_gnt, rd_gnt}), 32'b10);
            tick();
        end
        #1;
        chk("t5_rd_released", 32'(rd_gnt), 32'd1);
        tick();
        idle();

        // Cache stall: request presented but not granted.
        rd_req = 1; rd_addr = 32'h1000_0080; rd_tag = 7; dc_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t6_stall", 32'({dc_valid, rd_gnt}), 32'b10);
            tick();
        end
        dc_ready = 1;
        #1;
        chk("t6_rd_gnt", 32'(rd_gnt), 32'd1);
        tick();
        idle();
        tick();
        tick();

        // Randomized traffic with occasional flush and mid-run reset.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            rf_req    = ($urandom_range(0, 5) == 0);
            wr_req    = $urandom_range(0, 1) == 1;
            rd_req    = $urandom_range(0, 1) == 1;
            wr_urgent = ($urandom_range(0, 7) == 0);
            dc_ready  = ($urandom_range(0, 3) != 0);
            rf_addr   = 32'h2000_0000 | ($urandom_range(0, 3) << 4) |
                        ($urandom & 32'hF);
            rd_addr   = 32'h2000_0000 | ($urandom_range(0, 3) << 4) |
                        ($urandom & 32'hC);
            wr_addr   = $urandom;
            wr_data   = $urandom;
            wr_strb   = 4'($urandom);
            rd_size   = 2'($urandom_range(0, 2));
            rd_tag    = TAG_W'($urandom);
            dc_hit    = $urandom_range(0, 1) == 1;
            dc_rdata  = $urandom;
            tick();
        end
        idle();
        for (int i = 0; i < 3; i++) tick();
        chk("drain_empty", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single data-cache access port between three requesters:
  - refill requests from the miss/uncached handler;
  - store drains from the write buffer;
  - cached load launches from the read buffer.
- Tracks each accepted access through the fixed 2-cycle cache pipeline.
- Returns a tagged response so the read buffer can write back hits and mark misses.
- Sits between the LSU buffers and the data accessor.

Parameters:
- TAG_W, 7, width of the load id/tag carried through the pipeline.
- STARVE_MAX, 8, number of consecutive denied write-request cycles before writes outrank reads.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline flush; kills in-flight reads.
- rf_req  in  1  refill request.
- rf_addr  in  32  refill line address (bits 3:0 ignored).
- rf_gnt  out  1  refill accepted this cycle.
- wr_req  in  1  store drain request.
- wr_addr  in  32  store address.
- wr_data  in  32  store data.
- wr_strb  in  4  byte strobes.
- wr_urgent  in  1  write buffer nearly full.
- wr_gnt  out  1  store accepted this cycle.
- rd_req  in  1  load request.
- rd_addr  in  32  load address.
- rd_size  in  2  byte/half/word.
- rd_tag  in  TAG_W  load id.
- rd_gnt  out  1  load accepted this cycle.
- dc_valid  out  1  access presented to cache.
- dc_op  out  2  00 none, 01 read, 10 write, 11 refill.
- dc_addr  out  32  access address.
- dc_wdata  out  32  store data.
- dc_strb  out  4  store strobes.
- dc_size  out  2  load size.
- dc_ready  in  1  cache accepts the access.
- dc_hit  in  1  hit indication, valid 2 cycles after accept.
- dc_rdata  in  32  read data, aligned with dc_hit.
- rsp_valid  out  1  response for an accepted, unkilled access.
- rsp_op  out  2  op of the response.
- rsp_tag  out  TAG_W  load id (0 for non-reads).
- rsp_addr  out  32  access address.
- rsp_hit  out  1  copy of dc_hit.
- rsp_data  out  32  copy of dc_rdata.

Behaviour:
- Reset (rst high at posedge):
  - pipeline stages S1/S2 invalid; starvation counter cleared; flush_d cleared.
  - all grants, dc_valid and rsp_valid low.
  - dc_op = 00; address/data outputs 0.
- Priority each cycle, combinational, one winner:
  1. refill;
  2. write, if wr_urgent or counter == STARVE_MAX;
  3. read, if eligible;
  4. write.
- Winner's fields drive the dc_* outputs with dc_valid=1. dc_valid never depends on dc_ready.
- Grant: the winner's *_gnt = dc_valid & dc_ready, asserted in the same cycle. No grant when dc_ready=0; the requester holds its request.
- Read eligibility: rd_req & ~flush & ~flush_d & no refill in S1/S2 whose addr[31:4] equals rd_addr[31:4]. A blocked read does not hold the port, so a lower-priority write may win.
- Starvation counter (saturating at STARVE_MAX):
  - increments when wr_req & ~wr_gnt;
  - clears on wr_gnt;
  - holds when wr_req=0.
- Pipeline:
  - an accepted access enters S1 (op, addr, tag, kill=0);
  - S1 moves to S2 every cycle;
  - rsp_valid = S2.valid & ~S2.kill, so the response comes exactly 2 cycles after acceptance.
  - rsp_hit/rsp_data are taken directly from dc_hit/dc_rdata in that cycle.
- Flush:
  - sets kill on read entries in S1 and S2 in the flush cycle;
  - a read accepted in the flush cycle cannot occur, because reads are ineligible then;
  - flush_d (flush registered) also blocks reads for one more cycle;
  - writes and refills are never killed and still respond.
- Back-to-back accepts every cycle are supported (throughput 1/cycle).
- Reset mid-operation: in-flight entries are discarded; no response emerges.
- Simultaneous rf_req/wr_req/rd_req: exactly one grant. Others see *_gnt=0.

Test Plan:
- Reset, then rd_req=1, rd_addr=0x1000_0040, tag=5, dc_ready=1 -> rd_gnt=1 in cycle 0, dc_op=01. Two cycles later, with dc_hit=1, dc_rdata=0xDEADBEEF: rsp_valid=1, op=01, tag=5, data=0xDEADBEEF.
- rf_req, wr_req and rd_req all high with dc_ready=1 -> rf_gnt only. Next cycle, with rf_req dropped and wr_urgent=0: rd_gnt. With wr_urgent=1 instead: wr_gnt.
- wr_req held with rd_req continuously high -> reads win 8 cycles. On cycle 9 wr_gnt=1 and the counter returns to 0.
- Read accepted at cycle t, flush at t+1 -> no rsp at t+2. rd_req at t+1 and t+2 gets no grant; rd_gnt is possible at t+3. A write accepted at t still responds at t+2.
- Refill at 0x2000_0010 accepted, then rd_addr=0x2000_0018 -> read blocked for 2 cycles. A write to 0x3000_0000 is granted meanwhile. The read is granted in the 3rd cycle.
- dc_ready=0 for 3 cycles with rd_req high -> dc_valid=1, rd_gnt=0, no response. rd_gnt fires when dc_ready rises.
